tick_period_meter: RTL

- Receive-side counterpart of the tick/clock-divider generators in the stopwatch design.
- Consumes a periodic single-bit tick stream, such as a divider's terminal-count pulse or a debounced external pulse.
- Measures the number of `clk` cycles between successive rising edges and reports each measurement with a valid strobe.
- Flags lock when the measured period is within tolerance of an expected value, and flags timeout when ticks stop arriving; used for self-check of the timebase and for diagnostics.

---
 rtl/tick_period_meter.sv | 113 +++++++++++
 1 files changed

// File: rtl/tick_period_meter.sv
// Measures clk cycles between successive rising edges of a tick stream,
// reporting each period with a strobe plus lock and timeout status.
module tick_period_meter #(
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned TIMEOUT_CYCLES   = 200_000_000,
  parameter int unsigned EXPECTED_CYCLES  = 100_000_000,
  parameter int unsigned TOLERANCE_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             tick_in,
  output logic [WIDTH-1:0] period_out,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout,
  output logic             state_dbg
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT_CYCLES);
  localparam logic [WIDTH:0]   EXP_X     = (WIDTH+1)'(EXPECTED_CYCLES);
  localparam logic [WIDTH:0]   TOL_X     = (WIDTH+1)'(TOLERANCE_CYCLES);

  state_t           state, state_n;
  logic             tick_d;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] period_n;
  logic             valid_n, locked_n, timeout_n;
  logic             tick_edge;
  logic [WIDTH:0]   cnt_x, dev;
  logic             in_tol;

  assign tick_edge = tick_in & ~tick_d;
  assign state_dbg = (state == MEASURE);

  // Deviation is larger minus smaller so the unsigned subtraction never wraps.
  assign cnt_x  = {1'b0, cnt};
  assign dev    = (cnt_x >= EXP_X) ? (cnt_x - EXP_X) : (EXP_X - cnt_x);
  assign in_tol = (dev <= TOL_X);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      tick_d       <= 1'b0;
      cnt          <= '0;
      period_out   <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_n;
      tick_d       <= tick_in;
      cnt          <= cnt_n;
      period_out   <= period_n;
      period_valid <= valid_n;
      locked       <= locked_n;
      timeout      <= timeout_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    period_n  = period_out;
    valid_n   = 1'b0;
    locked_n  = locked;
    timeout_n = timeout;
    if (!enable) begin
      state_n   = IDLE;
      cnt_n     = '0;
      locked_n  = 1'b0;
      timeout_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tick_edge) begin
            state_n = MEASURE;
            cnt_n   = WIDTH'(1);
          end else begin
            cnt_n = '0;
          end
        end
        MEASURE: begin
          // An edge landing on the timeout count still yields a valid period.
          if (tick_edge) begin
            period_n  = cnt;
            valid_n   = 1'b1;
            cnt_n     = WIDTH'(1);
            locked_n  = in_tol;
            timeout_n = 1'b0;
          end else if (cnt == TIMEOUT_W) begin
            timeout_n = 1'b1;
            locked_n  = 1'b0;
            state_n   = IDLE;
            cnt_n     = '0;
          end else begin
            cnt_n = cnt + WIDTH'(1);
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

endmodule
